// File: rtl/stream_demux_1ton.sv
// One-to-N stream demultiplexer: routes each beat to a per-channel holding register,
// with an optional packet-lock mode that pins a whole packet to its first beat's select.

module stream_demux_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             ready,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_last,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last
);
  // A load wins over a drain so that a full register can be drained and refilled together.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      last  <= d_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module stream_demux_1ton #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_last,
  input  logic                lock_en,
  output logic [CH-1:0]       out_valid,
  input  logic [CH-1:0]       out_ready,
  output logic [CH*WIDTH-1:0] out_data,
  output logic [CH-1:0]       out_last,
  output logic                busy,
  output logic [7:0]          drop_cnt
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [SEL_W-1:0] lock_sel;
  logic [SEL_W-1:0] eff_sel;
  logic             in_range;
  logic             chan_free;
  logic             accept;
  logic [CH-1:0]    load;

  if (CH < 2 || CH > 16 || (1 << SEL_W) < CH) begin : g_bad_params
    $error("stream_demux_1ton: CH must be 2..16 and fit in SEL_W bits");
  end

  assign eff_sel = (state == LOCKED) ? lock_sel : in_sel;

  // Out-of-range selects fall through with chan_free=1 so the beat is swallowed.
  always_comb begin
    in_range  = 1'b0;
    chan_free = 1'b1;
    for (int k = 0; k < CH; k++) begin
      if (eff_sel == SEL_W'(k)) begin
        in_range  = 1'b1;
        chan_free = ~out_valid[k] | out_ready[k];
      end
    end
  end

  assign in_ready = chan_free;
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    assign load[k] = accept & (eff_sel == SEL_W'(k));
    stream_demux_ch #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .load   (load[k]),
      .ready  (out_ready[k]),
      .d_data (in_data),
      .d_last (in_last),
      .valid  (out_valid[k]),
      .data   (out_data[k*WIDTH +: WIDTH]),
      .last   (out_last[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= '0;
      busy     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept && !in_range && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      case (state)
        IDLE: begin
          // Out-of-range selects lock too, so the rest of that packet is dropped.
          if (accept && lock_en && !in_last) begin
            state    <= LOCKED;
            lock_sel <= in_sel;
            busy     <= 1'b1;
          end
        end
        LOCKED: begin
          if (accept && in_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
